// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter for one shared 4:1 datapath mux. A requester holds
//   req[i] high for as long as it needs the datapath. The winner keeps the
//   grant until it drops its request. There is always one IDLE cycle between
//   consecutive owners, and the search pointer advances past the last owner
//   so the other requesters get their turn.
//
//   Optional build macro: ARB_TIMEOUT_EN
//     When this macro is defined, a hold watchdog is compiled in. It forces
//     a release after MAX_HOLD consecutive grant cycles and pulses timeout
//     for one cycle. When the macro is undefined, timeout is tied to 0 and
//     ownership is unbounded.
//
// Parameters
//   MAX_HOLD  Maximum consecutive grant cycles per owner (2..255). Only used
//             when ARB_TIMEOUT_EN is defined.
//
// Ports
//   clk       Clock. All state changes happen on the rising edge.
//   rst       Asynchronous, active-high reset.
//   enable    Arbitration enable. No new grant is issued while it is low.
//   req[3:0]  Per-requester request level.
//   gnt[3:0]  Registered grant, one-hot or zero.
//   S[1:0]    Registered mux select. Holds the last owner while idle.
//   mux_en    Registered mux enable. High while a grant is active.
//   busy      High while in state GRANT.
//   timeout   One-cycle pulse on a watchdog release.
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] S,
    output logic       mux_en,
    output logic       busy,
    output logic       timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux4_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] pick;
    logic       found;
    logic [1:0] idx;

    // First requester found when searching ptr, ptr+1, ptr+2, ptr+3.
    // The loop runs from the farthest offset down to the nearest one, so
    // the nearest set bit is the last assignment and therefore wins.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign busy = (state == GRANT);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            gnt      <= 4'd0;
            S        <= 2'd0;
            mux_en   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (enable && found) begin
                        state    <= GRANT;
                        S        <= pick;
                        gnt      <= 4'b0001 << pick;
                        mux_en   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end else begin
                        gnt    <= 4'd0;
                        mux_en <= 1'b0;
                    end
                end
                GRANT: begin
                    // A normal release takes priority over the watchdog. An
                    // owner that drops its request on the limit cycle does
                    // not see a timeout.
                    if (!req[S]) begin
                        state  <= IDLE;
                        gnt    <= 4'd0;
                        mux_en <= 1'b0;
                        ptr    <= S + 2'd1;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt == HOLD_LAST) begin
                        state   <= IDLE;
                        gnt     <= 4'd0;
                        mux_en  <= 1'b0;
                        ptr     <= S + 2'd1;
                        timeout <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int MH = 4;
`else
    localparam int MH = 16;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] req = 4'd0;
    logic [3:0] gnt;
    logic [1:0] S;
    logic       mux_en, busy, timeout;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_on   = 1'b0;

    mux4_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .enable(enable), .req(req),
        .gnt(gnt), .S(S), .mux_en(mux_en), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model. owner = -1 means nobody holds the datapath.
    int m_owner = -1, m_ptr = 0, m_last = 0, m_hold = 0;
    bit m_to = 1'b0;

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1; m_ptr <= 0; m_last <= 0; m_hold <= 0; m_to <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (m_owner < 0) begin
                if (enable && req != 4'd0) begin
                    m_owner <= rr_pick(req, m_ptr);
                    m_last  <= rr_pick(req, m_ptr);
                    m_hold  <= 1;
                end
            end else if (!req[m_owner]) begin
                m_owner <= -1;
                m_ptr   <= (m_owner + 1) % 4;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_hold >= MH) begin
                // The owner has already been granted for MH cycles.
                m_owner <= -1;
                m_ptr   <= (m_owner + 1) % 4;
                m_to    <= 1'b1;
            end
`endif
            else m_hold <= m_hold + 1;
        end
    end

    // Per-cycle check against the model, plus structural invariants.
    always @(negedge clk) begin
        if (mon_on) begin
            logic [3:0] e_gnt;
            e_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'd0;
            n_checks++;
            if (gnt !== e_gnt || S !== 2'(m_last) || mux_en !== (m_owner >= 0) ||
                busy !== (m_owner >= 0) || timeout !== m_to) begin
                n_fail++;
                $display("FAIL model t=%0t gnt=%b S=%0d en=%b busy=%b to=%b expected gnt=%b S=%0d en=%b to=%b",
                         $time, gnt, S, mux_en, busy, timeout, e_gnt, m_last, (m_owner >= 0), m_to);
            end
            n_checks++;
            if ($countones(gnt) > 1 || mux_en !== (gnt != 4'd0)) begin
                n_fail++;
                $display("FAIL onehot gnt=%b mux_en=%b expected one-hot/zero gnt and mux_en=(gnt!=0)", gnt, mux_en);
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; req = 4'd0;
        tick; tick;
        n_checks++;
        if (gnt !== 4'd0 || S !== 2'd0 || mux_en !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset gnt=%b S=%0d en=%b busy=%b to=%b expected all zero", gnt, S, mux_en, busy, timeout);
        end
        rst = 1'b0; mon_on = 1'b1;
    endtask

    task automatic test_basic;
        enable = 1'b1; req = 4'b1010;
        tick;
        n_checks++;
        if (gnt !== 4'b0010 || S !== 2'd1 || mux_en !== 1'b1) begin
            n_fail++; $display("FAIL basic_grant gnt=%b S=%0d en=%b expected 0010 1 1", gnt, S, mux_en);
        end
        req = 4'b1000;
        tick;
        n_checks++;
        if (gnt !== 4'd0 || mux_en !== 1'b0 || S !== 2'd1) begin
            n_fail++; $display("FAIL basic_idle gnt=%b S=%0d en=%b expected 0000 1 0", gnt, S, mux_en);
        end
        tick;
        n_checks++;
        if (gnt !== 4'b1000 || S !== 2'd3) begin
            n_fail++; $display("FAIL basic_next gnt=%b S=%0d expected 1000 3", gnt, S);
        end
        req = 4'd0;
        tick;
    endtask

    task automatic test_rotation;
        int exp_o;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_o = g % 4;
            for (int c = 0; c < 3; c++) begin
                tick;
                n_checks++;
                if (gnt !== (4'b0001 << exp_o) || S !== 2'(exp_o)) begin
                    n_fail++; $display("FAIL rotation g=%0d c=%0d gnt=%b S=%0d expected owner %0d", g, c, gnt, S, exp_o);
                end
            end
            req[exp_o] = 1'b0;
            tick;
            n_checks++;
            if (gnt !== 4'd0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL rotation_gap g=%0d gnt=%b busy=%b expected 0000 0", g, gnt, busy);
            end
            req = 4'b1111;
        end
        req = 4'd0;
        tick;
    endtask

    task automatic test_enable;
        enable = 1'b0; req = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            tick;
            n_checks++;
            if (gnt !== 4'd0) begin
                n_fail++; $display("FAIL enable_low gnt=%b expected 0000", gnt);
            end
        end
        enable = 1'b1;
        tick;
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++; $display("FAIL enable_high gnt=%b expected 0100", gnt);
        end
        enable = 1'b0;
        tick; tick;
        n_checks++;
        if (gnt !== 4'b0100 || busy !== 1'b1) begin
            n_fail++; $display("FAIL enable_keep gnt=%b busy=%b expected 0100 1", gnt, busy);
        end
        req = 4'd0; enable = 1'b1;
        tick;
    endtask

    task automatic test_reset_mid_grant;
        req = 4'b0100;
        tick;
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++; $display("FAIL rstmid_pre gnt=%b expected 0100", gnt);
        end
        tick;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'd0 || S !== 2'd0 || mux_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async gnt=%b S=%0d en=%b busy=%b expected 0000 0 0 0", gnt, S, mux_en, busy);
        end
        req = 4'b1100; rst = 1'b0;
        tick;
        n_checks++;
        if (gnt !== 4'b0100 || S !== 2'd2) begin
            n_fail++; $display("FAIL rstmid_after gnt=%b S=%0d expected 0100 2", gnt, S);
        end
        req = 4'd0;
        tick;
    endtask

    task automatic test_hold_limit;
        // The pointer is 3 here, so owner 0 wins first.
        req = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            tick;
            n_checks++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                n_fail++; $display("FAIL hold c=%0d gnt=%b to=%b expected 0001 0", c, gnt, timeout);
            end
        end
`ifdef ARB_TIMEOUT_EN
        tick;
        n_checks++;
        if (gnt !== 4'd0 || timeout !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_pulse gnt=%b to=%b busy=%b expected 0000 1 0", gnt, timeout, busy);
        end
        tick;
        n_checks++;
        if (gnt !== 4'b0010 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_next gnt=%b to=%b expected 0010 0", gnt, timeout);
        end
`else
        for (int c = 0; c < 20; c++) tick;
        n_checks++;
        if (gnt !== 4'b0001 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL unbounded gnt=%b to=%b expected 0001 0", gnt, timeout);
        end
`endif
        req = 4'd0;
        tick; tick;
    endtask

    task automatic test_random;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            enable = ($urandom_range(0, 3) != 0);
            tick;
        end
        req = 4'd0; enable = 1'b1;
        tick; tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_rotation;
        test_enable;
        test_reset_mid_grant;
        test_hold_limit;
        test_random;
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, maximum consecutive grant cycles per owner (range 2..255).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 The block SHALL have port enable, input, 1, arbitration enable; when low, no new grant is issued.
REQ-005 The block SHALL have port req, input, 4, per-requester request; bit i is held high for as long as requester i wants the shared 4:1 datapath.
REQ-006 The block SHALL have port gnt, output, 4, one-hot (or zero) registered grant.
REQ-007 The block SHALL have port S, output, 2, registered select for the shared 4:1 mux; equals the index of the granted requester.
REQ-008 The block SHALL have port mux_en, output, 1, registered mux enable; high only while a grant is active.
REQ-009 The block SHALL have port busy, output, 1, high while in state GRANT.
REQ-010 The block SHALL have port timeout, output, 1, one-cycle pulse on forced release (present only with ARB_TIMEOUT_EN).

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-012 In IDLE with enable=1 and req!=0, the block SHALL select the first set req bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4) and enter GRANT on the next edge.
REQ-013 Grant latency SHALL be exactly 1 cycle: req sampled at edge N yields gnt, S and mux_en valid after edge N.
REQ-014 In IDLE with enable=0 or req=0, the block SHALL remain in IDLE with gnt=0 and mux_en=0.
REQ-015 In GRANT, the owner SHALL keep gnt while req[owner]=1, regardless of enable and of other req bits.
REQ-016 When req[owner]=0 is sampled in GRANT, the block SHALL go to IDLE on that edge: gnt=0, mux_en=0, and ptr=(owner+1) mod 4.
REQ-017 The block SHALL insert exactly one IDLE cycle between consecutive grants (no back-to-back handover).
REQ-018 In IDLE, S SHALL hold the last owner index; it SHALL change only when a new grant is issued.
REQ-019 At most one gnt bit SHALL be high in any cycle, and gnt[S] SHALL equal mux_en.
REQ-020 ptr SHALL be a 2-bit value that wraps 3->0.
REQ-021 Requests that rise and fall entirely while another owner holds the grant SHALL be ignored (no memory of requests).

Reset
REQ-022 On rst=1, asynchronously: state=IDLE, ptr=0, gnt=0, S=0, mux_en=0, busy=0, timeout=0, hold counter=0.
REQ-023 Reset asserted during GRANT SHALL drop gnt immediately without waiting for a clock edge; after release, arbitration restarts from ptr=0.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN SHALL compile in a hold watchdog; when undefined, timeout is tied to 0, no hold counter exists, and ownership is unbounded.
REQ-025 With ARB_TIMEOUT_EN, an 8-bit hold counter SHALL clear on grant and increment each GRANT cycle.
REQ-026 With ARB_TIMEOUT_EN, when the counter reaches MAX_HOLD-1 with req[owner] still 1, the block SHALL go to IDLE on the next edge, pulse timeout for that one cycle, and set ptr=(owner+1) mod 4.
REQ-027 With ARB_TIMEOUT_EN, a timed-out owner SHALL be re-eligible immediately and win only if no other requester is found first in rotation.
REQ-028 With ARB_TIMEOUT_EN, if req[owner] falls in the same cycle the limit is reached, the release SHALL be normal and timeout SHALL stay 0.

Verification
REQ-029 The bench SHALL cover: req=4'b1010 from reset -> gnt=4'b0010, S=1, mux_en=1 one cycle later; drop req[1] -> IDLE one cycle, then gnt=4'b1000, S=3.
REQ-030 The bench SHALL cover: all req=4'b1111 held, each owner releasing after 3 cycles -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-031 The bench SHALL cover: enable=0 with req=4'b0100 -> gnt stays 0; enable=1 -> gnt=4'b0100 next cycle; enable=0 during GRANT -> grant kept.
REQ-032 The bench SHALL cover: rst pulsed mid-GRANT (owner 2) -> gnt=0, S=0 without a clock edge; after release with req=4'b1100 -> gnt=4'b0100.
REQ-033 The bench SHALL cover, with ARB_TIMEOUT_EN and MAX_HOLD=4, req=4'b0011 held -> owner 0 holds 4 cycles, timeout pulses, IDLE, then owner 1 granted.
REQ-034 The bench SHALL check, every cycle in all tests, that gnt is one-hot or zero and that mux_en equals (gnt!=0).
